seg_display_scheduler: RTL
==========================

# seg_display_scheduler

Time-shares the board's 4-digit, 7-segment display among four 32-bit requesters (e.g. PC, ALU result, register read, memory data). Combines scan prescaler, digit multiplexer, halfword selection and round-robin source scheduling. Drives the anodes and segments directly and replaces the free-running divided-clock scan path with a single-clock, tick-enabled design. Sits at the board top level between the CPU debug taps and the display pins.

## Interface
- SCAN_DIV, 131072, CLK cycles per digit slot (≥2)
- DWELL_FRAMES, 256, full 4-digit frames shown per halfword in auto mode (≥1)
- CLK  in  1  single system clock, all logic on posedge
- RST_N  in  1  reset, synchronous, active-low
- Data  in  128  source i word = Data[32*i+31:32*i], i=0..3
- Req  in  4  source i requests display time
- Lock  in  1  1 = manual mode (SrcSel/Sel chosen), 0 = auto round-robin
- SrcSel  in  2  source index used in manual mode
- Sel  in  1  halfword used in manual mode (0 = [15:0], 1 = [31:16])
- AN  out  4  digit enables, active-low, one-hot-low; AN[0] = rightmost digit
- Seg  out  8  segments, active-low; Seg[0..6] = a..g, Seg[7] = dp
- CurSrc  out  2  source currently latched for display
- CurHalf  out  1  halfword currently latched

## Operation
- Prescaler: counts 0..SCAN_DIV-1, wraps. tick = 1 for the one cycle at SCAN_DIV-1.
- Digit index: 0..3, advances on tick. A frame boundary is a tick while digit == 3.
- Source, halfword, dwell count and shadow register change only at frame boundaries. No mixed frames.
- Shadow: at each frame boundary, shadow[15:0] <= the selected halfword of Data[next source], using the next-state selection. Data changes mid-frame are invisible until the next boundary.
- Digit d shows shadow[4d+3:4d], hex 0-F in standard common-anode encoding (0=C0 … 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E).
- Seg[7] is cleared (dp lit) on digit d == CurSrc; otherwise set.
- Auto mode (Lock=0):
  - Dwell counter counts frames.
  - At a boundary with dwell == DWELL_FRAMES-1: if half 0, go to half 1; if half 1, advance source.
  - Advance = first i in CurSrc+1, CurSrc+2, CurSrc+3, CurSrc (mod 4) with Req[i]=1, then half 0.
  - If only CurSrc requests, it stays and cycles back to half 0.
  - If Req[CurSrc] = 0 at any boundary, advance immediately with the same rule.
  - Any source or half change clears dwell.
- Blank state: when Req = 0000 in auto mode at a boundary, enter blank. AN = 1111, Seg = FF. CurSrc/CurHalf hold. Leave blank at the first boundary with any Req set, using the advance rule, half 0.
- Manual mode (Lock=1):
  - At each boundary: CurSrc <= SrcSel, CurHalf <= Sel, dwell cleared, blank cleared.
  - The source is shown regardless of Req.
- Lock falling: at the next boundary, resume auto. If Req[CurSrc] = 1, keep CurSrc with half 0; otherwise use the advance rule.

## Timing
- Reset (RST_N low at a posedge): prescaler=0, digit=0, dwell=0, shadow=0, blank=1, AN=1111, Seg=FF, CurSrc=0, CurHalf=0. A reset in the middle of a frame aborts it on that edge.
- AN and Seg are registered and change only on the edge where tick=1 (digit change). They are otherwise stable for SCAN_DIV cycles. AN and Seg never update on different edges.
- The first frame boundary after reset release is at cycle 4·SCAN_DIV. The display is blank until then.
- CurSrc and CurHalf update on the frame-boundary edge, the same edge on which AN/Seg load digit 0 of the new frame.
- Simultaneous events at a boundary:
  - Lock has priority over dwell expiry and Req changes.
  - Req drop has priority over dwell expiry.

## Structure
- Shared package seg_disp_pkg holds:
  - hex-to-segment constant table
  - SEG_BLANK = 8'hFF, AN_OFF = 4'hF
  - source-count constant (4)
  - dp-bit index
- Sub-module seg_hex_decode: combinational 4-bit to 7-segment active-low lookup. The dp bit is merged in the scheduler.
- Remaining logic stays in one module: prescaler, digit counter, scheduler FSM (BLANK/SHOW), dwell counter, shadow register.

## Test plan
Simulate with SCAN_DIV=4 and DWELL_FRAMES=2 (frame = 16 cycles).
- Reset: hold RST_N low 3 cycles with Req=1111 -> AN=1111, Seg=FF, CurSrc=0 throughout. Remains blank until cycle 16 after release.
- Single source: Req=0001, Data0=32'h1234ABCD.
  - Frames 1-2 show digits D,C,B,A. AN[0] low shows A1 with dp lit (Seg=21).
  - Frames 3-4 show 4,3,2,1.
  - Frame 5 shows the low half again.
- Round-robin: Req=1010 -> sequence src1 lo, src1 hi, src3 lo, src3 hi, src1 lo, each for 2 frames. dp digit tracks CurSrc.
- Req drop: Req=1010 showing src1 lo frame 1; drop Req[1] mid-frame -> current frame completes, next boundary switches to src3 half 0.
- Manual mode and tearing:
  - Lock=1, SrcSel=2, Sel=1, Req=0000, Data2=32'hBEEF0000 -> shows B,E,E,F from the next boundary on.
  - Toggling Sel and Data2 mid-frame leaves the current frame unchanged.
- Mid-frame reset: pulse RST_N low for one cycle during digit 2 -> next edge gives AN=1111, Seg=FF, counters 0. Display resumes at the boundary 16 cycles later.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants, state type and source-rotation helper for the display scheduler
package seg_disp_pkg;
  localparam int NUM_SRC = 4;
  localparam int DP_BIT = 7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  // first requester after cur in rotating order, falling back to cur itself
  function automatic logic [1:0] next_src(input logic [1:0] cur, input logic [NUM_SRC-1:0] req);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (req[idx]) r = idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit value to active-low a..g segment pattern
module seg_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // table lookup, dp handled by the caller
  always_comb seg = HEX_SEG[hex];
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: scans a 4-digit display, time-sharing it among four 32-bit sources
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 131072,
  parameter int DWELL_FRAMES = 256
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [32*NUM_SRC-1:0]  Data,
  input  logic [NUM_SRC-1:0]     Req,
  input  logic                   Lock,
  input  logic [1:0]             SrcSel,
  input  logic                   Sel,
  output logic [3:0]             AN,
  output logic [7:0]             Seg,
  output logic [1:0]             CurSrc,
  output logic                   CurHalf
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] digit_q, digit_d, src_q, src_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0] shadow_q, shadow_d;
  state_t state_q, state_d;
  logic half_q, half_d, man_q, man_d, tick, bnd;
  logic [3:0] an_q, an_d, nib;
  logic [7:0] seg_q, seg_d;
  logic [6:0] hex_seg;
  seg_hex_decode u_dec (.hex(nib), .seg(hex_seg));
  // scan timing, frame-boundary scheduling and next digit drive
  always_comb begin
    tick = presc_q == PW'(SCAN_DIV - 1);
    bnd = tick && digit_q == 2'd3;
    presc_d = tick ? '0 : presc_q + PW'(1);
    digit_d = tick ? digit_q + 2'd1 : digit_q;
    state_d = state_q;
    src_d = src_q;
    half_d = half_q;
    dwell_d = dwell_q;
    man_d = man_q;
    shadow_d = shadow_q;
    if (bnd) begin
      man_d = Lock;
      dwell_d = '0;
      state_d = ST_SHOW;
      if (Lock) begin
        src_d = SrcSel;
        half_d = Sel;
      end else if (Req == '0) state_d = ST_BLANK;
      else if (state_q == ST_BLANK || !Req[src_q]) begin
        src_d = next_src(src_q, Req);
        half_d = 1'b0;
      end else if (man_q) half_d = 1'b0;
      else if (dwell_q == DW'(DWELL_FRAMES - 1)) begin
        src_d = half_q ? next_src(src_q, Req) : src_q;
        half_d = !half_q;
      end else dwell_d = dwell_q + DW'(1);
      shadow_d = Data[{src_d, half_d, 4'b0} +: 16];
    end
    nib = shadow_d[{digit_d, 2'b0} +: 4];
    an_d = !tick ? an_q : state_d == ST_BLANK ? AN_OFF : ~(4'b1 << digit_d);
    seg_d = !tick ? seg_q : state_d == ST_BLANK ? SEG_BLANK : {digit_d != src_d, hex_seg};
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q <= '0;
      digit_q <= '0;
      dwell_q <= '0;
      shadow_q <= '0;
      state_q <= ST_BLANK;
      src_q <= '0;
      half_q <= 1'b0;
      man_q <= 1'b0;
      an_q <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      dwell_q <= dwell_d;
      shadow_q <= shadow_d;
      state_q <= state_d;
      src_q <= src_d;
      half_q <= half_d;
      man_q <= man_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign AN = an_q;
  assign Seg = seg_q;
  assign CurSrc = src_q;
  assign CurHalf = half_q;
endmodule
